// File: rtl/filter_run_ctrl.sv
// filter_run_ctrl: debounces four kernel-select buttons, queues the latest
// request, and sequences the filter processor through a frame-aligned
// reset/arm/run/done cycle using the selected kernel.

// Per-button conditioner: 2-flop synchronizer, saturating low-level counter,
// and a one-cycle press pulse on the cycle the counter first saturates.
module filter_run_ctrl_deb #(
  parameter int DEB_CYCLES = 4
) (
  input  logic CLK,
  input  logic reset,
  input  logic btn_n,
  output logic press
);
  localparam int            CW      = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Synchronizer resets to the released level so reset never looks like a press.
  // The pulse fires only on the increment that lands on DEB_MAX, so a held
  // button sits saturated and produces nothing further.
  always_ff @(posedge CLK) begin
    if (reset) begin
      sync  <= 2'b11;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn_n};
      press <= 1'b0;
      if (sync[1]) begin
        cnt <= '0;
      end else if (cnt != DEB_MAX) begin
        cnt   <= cnt + 1'b1;
        press <= (cnt == DEB_MAX - 1'b1);
      end
    end
  end
endmodule

module filter_run_ctrl #(
  parameter int          DEB_CYCLES = 4,
  parameter int          ARM_CYCLES = 4,
  parameter logic [31:0] END_PC     = 32'h0000_0100
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        kernel1,
  input  logic        kernel2,
  input  logic        kernel3,
  input  logic        identity,
  input  logic        frame_start,
  input  logic [31:0] PC,
  output logic [1:0]  kernel,
  output logic        proc_reset,
  output logic        proc_en,
  output logic        busy,
  output logic        done
);
  localparam int            NUM_BTN  = 4;
  localparam int            AW       = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam logic [AW-1:0] ARM_LOAD = AW'(ARM_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, WAIT_FRAME, ARM, RUN, DONE} state_t;

  typedef struct packed {
    logic       vld;
    logic [1:0] kernel;
  } req_t;

  typedef struct packed {
    logic proc_reset;
    logic proc_en;
    logic busy;
    logic done;
  } out_t;

  // Button index doubles as the kernel encoding; lower index wins ties.
  logic [NUM_BTN-1:0] btn_n;
  logic [NUM_BTN-1:0] press;
  logic               evt_vld;
  logic [1:0]         evt_kernel;

  state_t         state, state_nxt;
  req_t           pend;
  logic [AW-1:0]  arm_cnt;
  logic           take;
  out_t           out_nxt;

  assign btn_n = {identity, kernel3, kernel2, kernel1};

  genvar g;
  generate
    for (g = 0; g < NUM_BTN; g++) begin : g_deb
      filter_run_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .CLK   (CLK),
        .reset (reset),
        .btn_n (btn_n[g]),
        .press (press[g])
      );
    end
  endgenerate

  // Priority encode simultaneous presses: kernel1 > kernel2 > kernel3 > identity.
  always_comb begin
    evt_vld    = |press;
    evt_kernel = 2'd0;
    for (int i = NUM_BTN - 1; i >= 0; i--)
      if (press[i]) evt_kernel = 2'(i);
  end

  assign take = (state == WAIT_FRAME) && frame_start;

  // State register plus the request queue, arm counter and kernel latch.
  // A press coinciding with the frame-aligned take is the newest request,
  // so it is the one launched.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state   <= IDLE;
      pend    <= '0;
      arm_cnt <= '0;
      kernel  <= 2'd0;
    end else begin
      state <= state_nxt;
      if (take) begin
        pend.vld <= 1'b0;
        kernel   <= evt_vld ? evt_kernel : pend.kernel;
        arm_cnt  <= ARM_LOAD;
      end else begin
        if (evt_vld) pend <= '{vld: 1'b1, kernel: evt_kernel};
        if (state == ARM && arm_cnt != '0) arm_cnt <= arm_cnt - 1'b1;
      end
    end
  end

  // Next-state logic; frame_start only matters while waiting for a frame.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (pend.vld)        state_nxt = WAIT_FRAME;
      WAIT_FRAME: if (frame_start)     state_nxt = ARM;
      ARM:        if (arm_cnt == '0)   state_nxt = RUN;
      RUN:        if (PC == END_PC)    state_nxt = DONE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs track state.
  always_comb begin
    out_nxt            = '0;
    out_nxt.proc_reset = (state_nxt == IDLE) || (state_nxt == WAIT_FRAME) ||
                         (state_nxt == ARM);
    out_nxt.proc_en    = (state_nxt == RUN);
    out_nxt.busy       = (state_nxt == ARM) || (state_nxt == RUN);
    out_nxt.done       = (state_nxt == DONE);
  end

  // Output registers; reset holds the processor in reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      proc_reset <= 1'b1;
      proc_en    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      proc_reset <= out_nxt.proc_reset;
      proc_en    <= out_nxt.proc_en;
      busy       <= out_nxt.busy;
      done       <= out_nxt.done;
    end
  end
endmodule

// File: tb/tb_filter_run_ctrl.sv
// Directed bench for filter_run_ctrl: inputs driven and outputs checked on the
// falling edge; expected values are hand-derived from default parameters.
module tb_filter_run_ctrl;
  logic        CLK = 1'b0;
  logic        reset;
  logic [3:0]  btn;          // {identity, kernel3, kernel2, kernel1}, active low
  logic        frame_start;
  logic [31:0] PC;
  logic [1:0]  kernel;
  logic        proc_reset, proc_en, busy, done;

  int total  = 0;
  int passed = 0;
  int fails  = 0;
  int arm_n;

  filter_run_ctrl dut (
    .CLK         (CLK),
    .reset       (reset),
    .kernel1     (btn[0]),
    .kernel2     (btn[1]),
    .kernel3     (btn[2]),
    .identity    (btn[3]),
    .frame_start (frame_start),
    .PC          (PC),
    .kernel      (kernel),
    .proc_reset  (proc_reset),
    .proc_en     (proc_en),
    .busy        (busy),
    .done        (done)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  // Bounded wait for the processor enable to come up.
  task automatic wait_run(input string tag);
    for (int i = 0; i < 20 && !proc_en; i++) tick(1);
    chk(tag, proc_en, 1'b1);
  endtask

  initial begin
    btn = 4'hF; frame_start = 1'b0; PC = 32'h0; reset = 1'b1;
    tick(3);
    chk("rst_kernel", kernel, 2'd0);
    chk("rst_proc_reset", proc_reset, 1'b1);
    chk("rst_proc_en", proc_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    reset = 1'b0;

    // kernel2 held 6 cycles, then frame-aligned arm of exactly 4 cycles
    btn = 4'b1101; tick(6); btn = 4'hF; tick(4);
    chk("wait_frame_idle_busy", busy, 1'b0);
    pulse_fs();
    chk("k2_kernel", kernel, 2'd1);
    chk("k2_arm_busy", busy, 1'b1);
    chk("k2_arm_proc_reset", proc_reset, 1'b1);
    chk("k2_arm_proc_en", proc_en, 1'b0);
    arm_n = 1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (proc_en) break;
      if (busy && proc_reset) arm_n++;
    end
    chk("k2_arm_cycles", arm_n, 4);
    chk("k2_run_en", proc_en, 1'b1);
    chk("k2_run_busy", busy, 1'b1);
    chk("k2_run_proc_reset", proc_reset, 1'b0);

    // kernel3 press during RUN is held, run continues, kernel unchanged
    btn = 4'b1011; tick(8); btn = 4'hF; tick(2);
    chk("run_kernel_hold", kernel, 2'd1);
    chk("run_not_aborted", proc_en, 1'b1);
    PC = 32'h100; tick(1); PC = 32'h0;
    chk("end_done", done, 1'b1);
    chk("end_proc_en", proc_en, 1'b0);
    chk("end_busy", busy, 1'b0);
    chk("end_proc_reset", proc_reset, 1'b0);
    chk("end_kernel", kernel, 2'd1);
    tick(1);
    chk("pend_to_wait_done", done, 1'b0);
    chk("pend_to_wait_proc_reset", proc_reset, 1'b1);
    tick(3);
    chk("wait_holds", busy, 1'b0);
    pulse_fs();
    chk("k3_kernel", kernel, 2'd2);
    chk("k3_busy", busy, 1'b1);
    wait_run("k3_run");
    PC = 32'h100; tick(1); PC = 32'h0;
    chk("k3_done", done, 1'b1);
    pulse_fs(); tick(2);
    chk("fs_ignored_done", done, 1'b1);
    chk("fs_ignored_busy", busy, 1'b0);

    // kernel1 and identity together: one event, kernel1 wins
    btn = 4'b0110; tick(10); btn = 4'hF; tick(2);
    chk("dual_wait", done, 1'b0);
    pulse_fs();
    chk("dual_kernel", kernel, 2'd0);
    chk("dual_busy", busy, 1'b1);
    wait_run("dual_run");
    PC = 32'h100; tick(1); PC = 32'h0; tick(5);
    chk("dual_single_event", done, 1'b1);

    // Two short kernel1 pulses produce no event
    reset = 1'b1; tick(2); reset = 1'b0;
    btn = 4'b1110; tick(3); btn = 4'hF; tick(1);
    btn = 4'b1110; tick(3); btn = 4'hF; tick(10);
    pulse_fs(); tick(1);
    chk("short_busy", busy, 1'b0);
    chk("short_proc_reset", proc_reset, 1'b1);
    chk("short_done", done, 1'b0);

    // Reset during ARM with an identity request pending
    btn = 4'b1101; tick(6); btn = 4'hF; tick(4);
    btn = 4'b0111; tick(4);
    pulse_fs();
    chk("arm_rst_busy", busy, 1'b1);
    chk("arm_rst_kernel", kernel, 2'd1);
    tick(2);
    chk("arm_rst_still_arm", proc_reset & busy, 1'b1);
    reset = 1'b1; btn = 4'hF; tick(1); reset = 1'b0;
    chk("arm_rst_kernel0", kernel, 2'd0);
    chk("arm_rst_busy0", busy, 1'b0);
    chk("arm_rst_proc_reset", proc_reset, 1'b1);
    chk("arm_rst_proc_en", proc_en, 1'b0);
    tick(8);
    pulse_fs(); tick(2);
    chk("arm_rst_no_pend", busy, 1'b0);
    chk("arm_rst_no_done", done, 1'b0);

    // Reset mid-RUN with a request pending
    btn = 4'b1101; tick(6); btn = 4'hF; tick(4);
    pulse_fs();
    wait_run("mid_run");
    btn = 4'b1011; tick(8); btn = 4'hF;
    reset = 1'b1; tick(1); reset = 1'b0;
    chk("mid_rst_proc_en", proc_en, 1'b0);
    chk("mid_rst_proc_reset", proc_reset, 1'b1);
    tick(10);
    pulse_fs(); tick(2);
    chk("mid_rst_no_pend", busy, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
